// File: rtl/wbm_spi_cmd_pkg.sv
// Shared types and constants for the SPI-command Wishbone master.
package wbm_spi_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int        CMD_WE_BIT = 7;
  localparam logic [7:0] ERR_BYTE  = 8'hFF;

endpackage

// File: rtl/wbm_spi_cmd_clock_domain_import.sv
// Importer for a req/ack toggle CDC handshake carrying one byte.
// Latency: byte_vld 2 cycles after req toggles; ack toggles on the cycle byte_vld & byte_rdy.
// Backpressure: while byte_rdy is low the ack is withheld and the exporter stalls.
module clock_domain_import (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       byte_rdy,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       ack
);

  logic req_meta;
  logic req_s;

  // data is held stable by the exporter while req != ack, so no data sync is needed
  assign byte_vld = req_s ^ ack;
  assign byte_dat = data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
      ack      <= 1'b0;
    end else begin
      req_meta <= req;
      req_s    <= req_meta;
      if (byte_vld && byte_rdy) begin
        ack <= req_s;
      end
    end
  end

endmodule

// File: rtl/wbm_spi_cmd.sv
// SPI command byte(s) -> one classic Wishbone cycle; optional ack timeout via WBM_SPI_CMD_TIMEOUT_EN.
// Latency: cyc/stb 1 cycle after the consume cycle; tx_stb 1 cycle after wbm_ack.
// Backpressure: bytes are only consumed in IDLE/DATA; during a bus cycle the SPI side stalls.
module wbm_spi_cmd
  import wbm_spi_cmd_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              handshake_req,
  input  logic [7:0]        handshake_data,
  output logic              handshake_ack,
  input  logic              spi_csn,
  output logic              wbm_cyc,
  output logic              wbm_stb,
  output logic              wbm_we,
  output logic [ADDR_W-1:0] wbm_adr,
  output logic [7:0]        wbm_dat_o,
  input  logic [7:0]        wbm_dat_i,
  input  logic              wbm_ack,
  output logic [7:0]        tx_data,
  output logic              tx_stb
);

  if (ADDR_W < 1 || ADDR_W > 7 || TIMEOUT < 1) begin : g_param_check
    $error("wbm_spi_cmd: ADDR_W must be 1..7 and TIMEOUT at least 1");
  end

  state_t     state;
  logic       byte_vld;
  logic       byte_rdy;
  logic [7:0] byte_dat;
  logic [2:0] csn_sync;
  logic       frame_end;
  logic       drop_q;

`ifdef WBM_SPI_CMD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] to_cnt;
`endif

  assign byte_rdy = (state == ST_IDLE) || (state == ST_DATA);

  clock_domain_import u_import (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (handshake_req),
    .data     (handshake_data),
    .byte_rdy (byte_rdy),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat),
    .ack      (handshake_ack)
  );

  // Two sync flops plus one history flop; deselect (rising csn) ends the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csn_sync <= 3'b111;
    end else begin
      csn_sync <= {csn_sync[1:0], spi_csn};
    end
  end

  assign frame_end = csn_sync[1] & ~csn_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wbm_cyc   <= 1'b0;
      wbm_stb   <= 1'b0;
      wbm_we    <= 1'b0;
      wbm_adr   <= '0;
      wbm_dat_o <= 8'h00;
      tx_data   <= 8'h00;
      tx_stb    <= 1'b0;
      drop_q    <= 1'b0;
`ifdef WBM_SPI_CMD_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      tx_stb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (byte_vld) begin
            wbm_adr <= byte_dat[ADDR_W-1:0];
            if (byte_dat[CMD_WE_BIT]) begin
              state <= ST_DATA;
            end else begin
              state   <= ST_WB;
              wbm_cyc <= 1'b1;
              wbm_stb <= 1'b1;
              wbm_we  <= 1'b0;
              drop_q  <= 1'b0;
`ifdef WBM_SPI_CMD_TIMEOUT_EN
              to_cnt  <= '0;
`endif
            end
          end
        end
        ST_DATA: begin
          // A deselect abandons the half command, even if a byte is consumed alongside it.
          if (frame_end) begin
            state <= ST_IDLE;
          end else if (byte_vld) begin
            wbm_dat_o <= byte_dat;
            state     <= ST_WB;
            wbm_cyc   <= 1'b1;
            wbm_stb   <= 1'b1;
            wbm_we    <= 1'b1;
            drop_q    <= 1'b0;
`ifdef WBM_SPI_CMD_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        ST_WB: begin
          if (frame_end) begin
            drop_q <= 1'b1;
          end
          if (wbm_ack) begin
            state   <= ST_IDLE;
            wbm_cyc <= 1'b0;
            wbm_stb <= 1'b0;
            wbm_we  <= 1'b0;
            if (!wbm_we && !drop_q && !frame_end) begin
              tx_data <= wbm_dat_i;
              tx_stb  <= 1'b1;
            end
          end
`ifdef WBM_SPI_CMD_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= ST_IDLE;
            wbm_cyc <= 1'b0;
            wbm_stb <= 1'b0;
            wbm_we  <= 1'b0;
            if (!wbm_we && !drop_q && !frame_end) begin
              tx_data <= ERR_BYTE;
              tx_stb  <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbm_spi_cmd.sv
// Scoreboard bench for wbm_spi_cmd: directed commands, monitor checks bus cycles and tx strobes.
module tb_wbm_spi_cmd;

  typedef struct packed {
    logic       we;
    logic [6:0] adr;
    logic [7:0] dat;
  } wb_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       handshake_req;
  logic [7:0] handshake_data;
  logic       handshake_ack;
  logic       spi_csn;
  logic       wbm_cyc;
  logic       wbm_stb;
  logic       wbm_we;
  logic [6:0] wbm_adr;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_ack;
  logic [7:0] tx_data;
  logic       tx_stb;

  int checks   = 0;
  int failures = 0;

  wb_exp_t    exp_wb[$];
  logic [7:0] exp_tx[$];

  int   ack_delay = 0;
  logic ack_hold  = 1'b0;
  logic [7:0] slave_dat = 8'h00;
  int   ack_toggles = 0;

  always #5 clk = ~clk;

  wbm_spi_cmd #(.ADDR_W(7), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .handshake_req  (handshake_req),
    .handshake_data (handshake_data),
    .handshake_ack  (handshake_ack),
    .spi_csn        (spi_csn),
    .wbm_cyc        (wbm_cyc),
    .wbm_stb        (wbm_stb),
    .wbm_we         (wbm_we),
    .wbm_adr        (wbm_adr),
    .wbm_dat_o      (wbm_dat_o),
    .wbm_dat_i      (wbm_dat_i),
    .wbm_ack        (wbm_ack),
    .tx_data        (tx_data),
    .tx_stb         (tx_stb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Wishbone slave: acks after ack_delay wait states unless ack_hold is set.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    wbm_ack   = 1'b0;
    wbm_dat_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      wbm_ack = 1'b0;
      if (wbm_cyc && wbm_stb && !ack_hold) begin
        if (wait_cnt >= ack_delay) begin
          wbm_ack   = 1'b1;
          wbm_dat_i = slave_dat;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each bus-cycle start and each tx strobe.
  initial begin
    int      cyc_n;
    int      last_cyc_n;
    logic    prev_cyc;
    logic    prev_ack;
    logic    prev_hack;
    wb_exp_t e;
    logic [7:0] et;
    cyc_n = 0; last_cyc_n = -10; prev_cyc = 1'b0; prev_ack = 1'b0; prev_hack = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (wbm_cyc && wbm_stb && !prev_cyc) begin
        if (exp_wb.size() == 0) begin
          chk("wb_unexpected_cycle", {wbm_we, wbm_adr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_wb.pop_front();
          chk("wb_cmd", {wbm_we, wbm_adr, (wbm_we ? wbm_dat_o : 8'h00)},
              {e.we, e.adr, (e.we ? e.dat : 8'h00)});
        end
      end
      if (prev_cyc && prev_ack) chk("cyc_drop_after_ack", {wbm_cyc, wbm_stb}, 0);
      if (wbm_cyc) last_cyc_n = cyc_n;
      if (tx_stb) begin
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected_stb", tx_data, 32'hFFFF_FFFF);
        end else begin
          et = exp_tx.pop_front();
          chk("tx_data", tx_data, et);
          chk("tx_latency", cyc_n, last_cyc_n + 1);
        end
      end
      if (handshake_ack !== prev_hack) ack_toggles++;
      prev_hack = handshake_ack;
      prev_cyc  = wbm_cyc && wbm_stb;
      prev_ack  = wbm_ack;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (handshake_ack !== handshake_req && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) chk("send_wait_timeout", n, 0);
    @(posedge clk);
    #1;
    handshake_data = b;
    handshake_req  = ~handshake_req;
  endtask

  task automatic wait_cyc(input string name);
    int n;
    n = 0;
    while (!wbm_cyc && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk(name, 0, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_wb.size() != 0 || exp_tx.size() != 0 || wbm_cyc ||
            handshake_ack !== handshake_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk(name, n, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t0;
    int n;
    logic a0;
    logic changed;
    rst_n          = 1'b0;
    handshake_req  = 1'b0;
    handshake_data = 8'h00;
    spi_csn        = 1'b0;
    #23;
    chk("reset_outputs", {wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat_o, tx_data, tx_stb, handshake_ack}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Write: 0x85 then 0x3C -> we=1 adr=0x05 dat=0x3C, no tx strobe, two acks.
    t0 = ack_toggles;
    ack_delay = 2;
    exp_wb.push_back('{we: 1'b1, adr: 7'h05, dat: 8'h3C});
    send_byte(8'h85);
    send_byte(8'h3C);
    drain("write_drain");
    chk("write_ack_toggles", ack_toggles - t0, 2);

    // Read: 0x12, slave returns 0xA7.
    ack_delay = 1;
    slave_dat = 8'hA7;
    exp_wb.push_back('{we: 1'b0, adr: 7'h12, dat: 8'h00});
    exp_tx.push_back(8'hA7);
    send_byte(8'h12);
    drain("read_drain");

    // Backpressure: second byte arrives while the slave withholds ack.
    ack_hold  = 1'b1;
    slave_dat = 8'h5A;
    exp_wb.push_back('{we: 1'b0, adr: 7'h01, dat: 8'h00});
    exp_tx.push_back(8'h5A);
    send_byte(8'h01);
    wait_cyc("bp_cyc_timeout");
    exp_wb.push_back('{we: 1'b0, adr: 7'h02, dat: 8'h00});
    exp_tx.push_back(8'h5A);
    send_byte(8'h02);
    a0 = handshake_ack;
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (handshake_ack !== a0) changed = 1'b1;
    end
    chk("bp_ack_held", changed, 0);
    chk("bp_cyc_held", wbm_cyc, 1);
    ack_hold = 1'b0;
    n = 0;
    while (handshake_ack !== handshake_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_ack_after_idle", handshake_ack, handshake_req);
    drain("bp_drain");

    // Frame abort: write command then deselect before the data byte.
    send_byte(8'h80);
    repeat (6) @(posedge clk);
    #1 spi_csn = 1'b1;
    repeat (6) @(posedge clk);
    #1 spi_csn = 1'b0;
    repeat (4) @(posedge clk);
    slave_dat = 8'hC1;
    exp_wb.push_back('{we: 1'b0, adr: 7'h02, dat: 8'h00});
    exp_tx.push_back(8'hC1);
    send_byte(8'h02);
    drain("abort_drain");

    // Reset while a bus cycle is open.
    ack_hold = 1'b1;
    exp_wb.push_back('{we: 1'b0, adr: 7'h05, dat: 8'h00});
    send_byte(8'h05);
    wait_cyc("rst_cyc_timeout");
    @(posedge clk); #1;
    rst_n = 1'b0;
    handshake_req = 1'b0;
    #1;
    chk("reset_mid_cycle", {wbm_cyc, wbm_stb, tx_stb, handshake_ack}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ack_hold = 1'b0;
    repeat (3) @(posedge clk);
    slave_dat = 8'hC3;
    exp_wb.push_back('{we: 1'b0, adr: 7'h44, dat: 8'h00});
    exp_tx.push_back(8'hC3);
    send_byte(8'h44);
    drain("post_reset_drain");

`ifdef WBM_SPI_CMD_TIMEOUT_EN
    // Timeout: no ack -> 16 cycles of cyc, then error byte.
    ack_hold = 1'b1;
    exp_wb.push_back('{we: 1'b0, adr: 7'h03, dat: 8'h00});
    exp_tx.push_back(8'hFF);
    send_byte(8'h03);
    wait_cyc("to_cyc_timeout");
    n = 0;
    while (wbm_cyc && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", n, 16);
    drain("timeout_drain");
    ack_hold = 1'b0;
`endif

    chk("sb_wb_left", exp_wb.size(), 0);
    chk("sb_tx_left", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wbm_spi_cmd.md
Name: wbm_spi_cmd

Overview:
- Wishbone-clock-domain consumer of the bytes exported by the SPI receive stage over the req/ack clock-domain-crossing handshake.
- Synchronises the handshake, then parses a command byte and an optional data byte.
- Runs one classic Wishbone master cycle per command.
- On reads, hands the returned byte to the SPI transmit path as a single strobe.

Parameters:
- ADDR_W, 7: Wishbone address width; taken from command bits [ADDR_W-1:0]; legal range 1..7.
- TIMEOUT, 255: cycles to wait for wbm_ack before abort; used only with the optional feature.

Ports:
- clk  in  1  Wishbone clock.
- rst_n  in  1  asynchronous active-low reset.
- handshake_req  in  1  toggle from the SPI receive stage; spi_sck domain.
- handshake_data  in  8  byte from the SPI receive stage; stable while req != ack.
- handshake_ack  out  1  toggle back to the SPI receive stage.
- spi_csn  in  1  raw SPI chip select; asynchronous.
- wbm_cyc  out  1  Wishbone cycle.
- wbm_stb  out  1  Wishbone strobe.
- wbm_we  out  1  Wishbone write enable.
- wbm_adr  out  ADDR_W  Wishbone address.
- wbm_dat_o  out  8  Wishbone write data.
- wbm_dat_i  in  8  Wishbone read data.
- wbm_ack  in  1  Wishbone acknowledge.
- tx_data  out  8  read result for the SPI transmit path.
- tx_stb  out  1  one-cycle pulse; tx_data valid.

Behaviour:
- Reset is asynchronous, active-low. All outputs and state reset to 0; FSM resets to IDLE; sync flops reset to 0. csn sync flops reset to 1.
- CDC, byte receive:
  - handshake_req passes through a 2-flop synchroniser to req_s.
  - A byte is pending when req_s != handshake_ack.
  - The byte is consumed only in IDLE or DATA. Consume = latch handshake_data and set handshake_ack <= req_s in the same cycle.
  - In any other state, pending bytes are held off; this is backpressure, and the SPI side stalls.
- spi_csn passes through a 2-flop synchroniser. A synced 0->1 edge (deselect) is a frame end.
- Command byte: bit7 = we; bits[ADDR_W-1:0] = address; unused bits are ignored.
- FSM:
  - IDLE: on consume, latch we/adr.
    - we=1 -> DATA.
    - we=0 -> WB.
  - DATA: on consume, latch wbm_dat_o -> WB.
  - WB: wbm_cyc = wbm_stb = 1, wbm_we = latched we. Entry is registered, so cyc/stb rise 1 cycle after the consume cycle.
    - On wbm_ack: cyc/stb drop next edge.
    - If read: tx_data <= wbm_dat_i, tx_stb = 1 for exactly one cycle.
    - Then -> IDLE.
- Latency: read command consumed at cycle N -> cyc/stb high at N+1 -> ack at N+1+k -> tx_stb at N+2+k.
- wbm_ack while not in WB is ignored.
- Frame end handling:
  - In IDLE: no effect.
  - In DATA: FSM -> IDLE and the half command is discarded.
  - In WB: the cycle completes normally; a read result is dropped (no tx_stb), then -> IDLE.
- Frame end and consume in the same cycle: frame end wins in DATA, so the byte is acked but discarded. In IDLE the byte is accepted.
- Reset mid-WB: cyc/stb deassert immediately (asynchronous); handshake_ack returns to 0.

Optional Feature:
- WBM_SPI_CMD_TIMEOUT_EN defined:
  - An 8+-bit counter (width from TIMEOUT) clears on WB entry and counts each WB cycle.
  - On reaching TIMEOUT without ack: cyc/stb drop; a read emits tx_data = 8'hFF with tx_stb; -> IDLE.
  - An ack in the same cycle as the timeout takes priority as a normal ack.
- Undefined: no counter; WB waits for ack indefinitely.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, DATA, WB).
  - Command field constants: CMD_WE_BIT = 7.
  - Timeout error byte: ERR_BYTE = 8'hFF.
- Sub-module clock_domain_import: 2-flop req synchroniser plus pending/ack toggle logic; 8-bit data.
  - It mirrors the export side and is reused by any future CDC importer.
- The csn synchroniser is inline.

Test Plan:
- Write: toggle req with 8'h85, then 8'h3C -> one cycle with cyc=stb=we=1, adr=7'h05, dat_o=8'h3C; ack after 3 cycles -> cyc low next edge; no tx_stb; ack toggled twice.
- Read: byte 8'h12; slave ack with dat_i=8'hA7 after 2 cycles -> we=0, adr=7'h12; tx_data=8'hA7 with a single tx_stb exactly 1 cycle after ack.
- Backpressure: send 8'h01 (read), then a second byte while the slave withholds ack for 20 cycles -> handshake_ack stays unchanged for the second byte until IDLE, then toggles; second command executes.
- Frame abort: 8'h80, then raise spi_csn before the data byte -> FSM IDLE, no Wishbone cycle; a following 8'h02 read executes correctly.
- Reset mid-cycle: assert rst_n=0 while cyc=1 -> cyc/stb/tx_stb/handshake_ack all 0 immediately; after release, a normal read works.
- Timeout (macro on, TIMEOUT=16): read with no ack -> cyc drops after 16 cycles; tx_data=8'hFF, tx_stb=1.
